// File: rtl/reg_bank_pkg.sv
// Shared types and helpers for the parametrised register bank.
package reg_bank_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } clr_state_e;

  localparam int DEF_DW    = 8;
  localparam int DEF_NREGS = 4;

  function automatic int aw_of(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

endpackage

// File: rtl/reg_bank_clr_seq.sv
// Clear sequencer: walks the register index once per clr request, then pulses clr_done.
//
// state | meaning
// IDLE  | writes allowed, waiting for clr
// CLEAR | zeroing register[idx], one per cycle
// DONE  | one-cycle clr_done pulse, still busy
module reg_bank_clr_seq
  import reg_bank_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  parameter int AW    = aw_of(NREGS)
) (
  input  logic          clk,
  input  logic          r,
  input  logic          clr,
  output logic          idle,
  output logic          clr_en,
  output logic [AW-1:0] clr_idx,
  output logic          busy,
  output logic          clr_done
);

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  clr_state_e    state, state_nxt;
  logic [AW-1:0] idx, idx_nxt;

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    idle      = 1'b0;
    clr_en    = 1'b0;
    busy      = 1'b0;
    clr_done  = 1'b0;
    case (state)
      IDLE: begin
        idle = 1'b1;
        if (clr) begin
          state_nxt = CLEAR;
          idx_nxt   = '0;
        end
      end
      CLEAR: begin
        clr_en  = 1'b1;
        busy    = 1'b1;
        idx_nxt = idx + 1'b1;
        if (idx == LAST) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        clr_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign clr_idx = idx;

endmodule

// File: rtl/reg_bank_param.sv
// N x DW register bank: two combinational read ports, one write port, sequenced clear.
// Optional same-cycle write-to-read forwarding when REG_BANK_BYPASS_EN is defined.
module reg_bank_param
  import reg_bank_pkg::*;
#(
  parameter int   DW      = DEF_DW,
  parameter int   NREGS   = DEF_NREGS,
  parameter bit   ZERO_R0 = 1'b0,
  localparam int  AW      = aw_of(NREGS)
) (
  input  logic          clk,
  input  logic          r,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra,
  input  logic [AW-1:0] rb,
  input  logic          clr,
  output logic [DW-1:0] s_ra,
  output logic [DW-1:0] s_rb,
  output logic          busy,
  output logic          clr_done
);

  logic [DW-1:0] regs [NREGS];
  logic          idle;
  logic          clr_en;
  logic [AW-1:0] clr_idx;
  logic          wr_acc;

  reg_bank_clr_seq #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_clr_seq (
    .clk      (clk),
    .r        (r),
    .clr      (clr),
    .idle     (idle),
    .clr_en   (clr_en),
    .clr_idx  (clr_idx),
    .busy     (busy),
    .clr_done (clr_done)
  );

  // clr wins over a same-cycle write; r gates forwarding while reset is held
  assign wr_acc = idle && !clr && we && r && !(ZERO_R0 && (wa == '0));

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (clr_en) begin
      regs[clr_idx] <= '0;
    end else if (wr_acc) begin
      regs[wa] <= wd;
    end
  end

  always_comb begin
    s_ra = regs[ra];
    s_rb = regs[rb];
`ifdef REG_BANK_BYPASS_EN
    if (wr_acc && (wa == ra)) s_ra = wd;
    if (wr_acc && (wa == rb)) s_rb = wd;
`endif
    if (ZERO_R0 && (ra == '0)) s_ra = '0;
    if (ZERO_R0 && (rb == '0)) s_rb = '0;
  end

endmodule

// File: tb/tb_reg_bank_param.sv
// Self-checking bench for reg_bank_param: directed scenarios plus randomized traffic against a timeline model.
module tb_reg_bank_param;

  localparam int NR  = 4;
  localparam int NRZ = 8;

`ifdef REG_BANK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        r   = 1'b0;
  logic        we, clr;
  logic [1:0]  wa, ra, rb;
  logic [7:0]  wd;
  logic [7:0]  s_ra, s_rb;
  logic        busy, clr_done;

  logic        we_z, clr_z;
  logic [2:0]  wa_z, ra_z, rb_z;
  logic [15:0] wd_z;
  logic [15:0] s_ra_z, s_rb_z;
  logic        busy_z, clr_done_z;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem  [NR];
  logic [15:0] memz [NRZ];
  int cyc   = 0;
  int clr_t = -1000;

  reg_bank_param dut (
    .clk(clk), .r(r), .we(we), .wa(wa), .wd(wd), .ra(ra), .rb(rb), .clr(clr),
    .s_ra(s_ra), .s_rb(s_rb), .busy(busy), .clr_done(clr_done)
  );

  reg_bank_param #(.DW(16), .NREGS(8), .ZERO_R0(1'b1)) dut_z (
    .clk(clk), .r(r), .we(we_z), .wa(wa_z), .wd(wd_z), .ra(ra_z), .rb(rb_z), .clr(clr_z),
    .s_ra(s_ra_z), .s_rb(s_rb_z), .busy(busy_z), .clr_done(clr_done_z)
  );

  always #5 clk = ~clk;

  // Reference model: sweep expressed as "cycles elapsed since clr was accepted"
  function automatic bit m_busy();
    int d = cyc - clr_t;
    return (d >= 1) && (d <= NR + 1);
  endfunction

  function automatic bit m_done();
    return (cyc - clr_t) == NR + 1;
  endfunction

  function automatic logic [7:0] m_read(input logic [1:0] a);
    if (BYP && !m_busy() && !clr && we && (wa == a)) return wd;
    return mem[a];
  endfunction

  function automatic logic [15:0] mz_read(input logic [2:0] a);
    if (a == 3'd0) return 16'h0000;
    if (BYP && we_z && !clr_z && !busy_z && (wa_z == a)) return wd_z;
    return memz[a];
  endfunction

  task automatic m_tick();
    int d = cyc - clr_t;
    if (d >= 1 && d <= NR) mem[d-1] = 8'h00;
    else if (!m_busy()) begin
      if (clr) clr_t = cyc;
      else if (we) mem[wa] = wd;
    end
    if (we_z && !clr_z && (wa_z != 3'd0)) memz[wa_z] = wd_z;
    cyc++;
  endtask

  task automatic m_reset();
    for (int i = 0; i < NR; i++) mem[i] = 8'h00;
    for (int i = 0; i < NRZ; i++) memz[i] = 16'h0000;
    clr_t = cyc - 1000;
  endtask

  task automatic cycle();
    @(posedge clk);
    m_tick();
    #1;
  endtask

  task automatic test_reset();
    #2;
    ra = 2'd1; rb = 2'd2; ra_z = 3'd5; rb_z = 3'd7;
    #1;
    checks++; if (s_ra !== 8'h00) begin errors++; $display("FAIL reset_s_ra got=%h exp=00", s_ra); end
    checks++; if (s_rb !== 8'h00) begin errors++; $display("FAIL reset_s_rb got=%h exp=00", s_rb); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (clr_done !== 1'b0) begin errors++; $display("FAIL reset_clr_done got=%b exp=0", clr_done); end
    checks++; if (s_ra_z !== 16'h0000) begin errors++; $display("FAIL reset_s_ra_z got=%h exp=0000", s_ra_z); end
    @(negedge clk);
    r = 1'b1;
    m_reset();
  endtask

  task automatic test_write_read();
    we = 1'b1; wa = 2'd2; wd = 8'hA5;
    cycle();
    wa = 2'd3; wd = 8'h3C;
    cycle();
    we = 1'b0; ra = 2'd2; rb = 2'd3;
    #1;
    checks++; if (s_ra !== 8'hA5) begin errors++; $display("FAIL wr_s_ra got=%h exp=a5", s_ra); end
    checks++; if (s_rb !== 8'h3C) begin errors++; $display("FAIL wr_s_rb got=%h exp=3c", s_rb); end
    r = 1'b0;
    #1;
    checks++; if (s_ra !== 8'h00) begin errors++; $display("FAIL async_rst_s_ra got=%h exp=00", s_ra); end
    checks++; if (s_rb !== 8'h00) begin errors++; $display("FAIL async_rst_s_rb got=%h exp=00", s_rb); end
    m_reset();
    @(negedge clk);
    r = 1'b1;
  endtask

  task automatic test_clear_sweep();
    logic [7:0] fill [NR];
    fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;
    for (int i = 0; i < NR; i++) begin
      we = 1'b1; wa = 2'(i); wd = fill[i];
      cycle();
    end
    we = 1'b0; clr = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sweep_busy_t got=%b exp=0", busy); end
    cycle();
    clr = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      ra = 2'd0; rb = 2'd3;
      #1;
      checks++; if (busy !== (k <= 5)) begin errors++; $display("FAIL sweep_busy k=%0d got=%b exp=%b", k, busy, (k <= 5)); end
      checks++; if (clr_done !== (k == 5)) begin errors++; $display("FAIL sweep_done k=%0d got=%b exp=%b", k, clr_done, (k == 5)); end
      if (k == 2) begin
        checks++; if (s_ra !== 8'h00) begin errors++; $display("FAIL sweep_partial_r0 got=%h exp=00", s_ra); end
        checks++; if (s_rb !== 8'h44) begin errors++; $display("FAIL sweep_partial_r3 got=%h exp=44", s_rb); end
      end
      if (k == 6) begin
        for (int p = 0; p < NR; p += 2) begin
          ra = 2'(p); rb = 2'(p + 1);
          #1;
          checks++; if (s_ra !== 8'h00) begin errors++; $display("FAIL sweep_end r%0d got=%h exp=00", p, s_ra); end
          checks++; if (s_rb !== 8'h00) begin errors++; $display("FAIL sweep_end r%0d got=%h exp=00", p + 1, s_rb); end
        end
      end else begin
        cycle();
      end
    end
  endtask

  task automatic test_busy_block();
    int pulses = 0;
    we = 1'b1; wa = 2'd1; wd = 8'h66;
    cycle();
    we = 1'b0; clr = 1'b1;
    cycle();
    for (int k = 1; k <= 12; k++) begin
      we = (k <= 5); clr = (k == 3); wa = 2'd1; wd = 8'hFF; ra = 2'd1; rb = 2'd0;
      #1;
      if (clr_done === 1'b1) pulses++;
      checks++; if (busy !== (k <= 5)) begin errors++; $display("FAIL blk_busy k=%0d got=%b exp=%b", k, busy, (k <= 5)); end
      checks++; if (s_ra !== m_read(ra)) begin errors++; $display("FAIL blk_s_ra k=%0d got=%h exp=%h", k, s_ra, m_read(ra)); end
      cycle();
    end
    we = 1'b0; clr = 1'b0; ra = 2'd1;
    #1;
    checks++; if (pulses != 1) begin errors++; $display("FAIL blk_pulses got=%0d exp=1", pulses); end
    checks++; if (s_ra !== 8'h00) begin errors++; $display("FAIL blk_r1 got=%h exp=00", s_ra); end
  endtask

  task automatic test_priority_reset();
    we = 1'b1; wa = 2'd2; wd = 8'h5C;
    cycle();
    clr = 1'b1; we = 1'b1; wa = 2'd2; wd = 8'h99; ra = 2'd2;
    #1;
    checks++; if (s_ra !== 8'h5C) begin errors++; $display("FAIL prio_fwd got=%h exp=5c", s_ra); end
    cycle();
    clr = 1'b0; we = 1'b0;
    #1;
    checks++; if (s_ra !== 8'h5C) begin errors++; $display("FAIL prio_drop got=%h exp=5c", s_ra); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL prio_busy got=%b exp=1", busy); end
    cycle();
    #2;
    r = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (clr_done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", clr_done); end
    for (int p = 0; p < NR; p += 2) begin
      ra = 2'(p); rb = 2'(p + 1);
      #1;
      checks++; if (s_ra !== 8'h00) begin errors++; $display("FAIL midrst r%0d got=%h exp=00", p, s_ra); end
      checks++; if (s_rb !== 8'h00) begin errors++; $display("FAIL midrst r%0d got=%h exp=00", p + 1, s_rb); end
    end
    m_reset();
    @(negedge clk);
    r = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      checks++; if (clr_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_after k=%0d busy=%b done=%b exp=0/0", k, busy, clr_done); end
    end
  endtask

  task automatic test_bypass();
    we = 1'b1; wa = 2'd1; wd = 8'h5A; ra = 2'd1; rb = 2'd2;
    #1;
    checks++; if (s_ra !== (BYP ? 8'h5A : 8'h00)) begin errors++; $display("FAIL byp_same_cycle got=%h exp=%h", s_ra, (BYP ? 8'h5A : 8'h00)); end
    checks++; if (s_rb !== 8'h00) begin errors++; $display("FAIL byp_other_port got=%h exp=00", s_rb); end
    cycle();
    we = 1'b0;
    #1;
    checks++; if (s_ra !== 8'h5A) begin errors++; $display("FAIL byp_next_cycle got=%h exp=5a", s_ra); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      we  = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 15) == 0);
      wa  = 2'($urandom); ra = 2'($urandom); rb = 2'($urandom);
      wd  = 8'($urandom);
      #1;
      checks++; if (s_ra !== m_read(ra)) begin errors++; $display("FAIL rand_s_ra n=%0d got=%h exp=%h", n, s_ra, m_read(ra)); end
      checks++; if (s_rb !== m_read(rb)) begin errors++; $display("FAIL rand_s_rb n=%0d got=%h exp=%h", n, s_rb, m_read(rb)); end
      checks++; if (busy !== m_busy()) begin errors++; $display("FAIL rand_busy n=%0d got=%b exp=%b", n, busy, m_busy()); end
      checks++; if (clr_done !== m_done()) begin errors++; $display("FAIL rand_done n=%0d got=%b exp=%b", n, clr_done, m_done()); end
      cycle();
    end
    we = 1'b0; clr = 1'b0;
    for (int k = 0; k < 8; k++) cycle();
  endtask

  task automatic test_zero_r0();
    we_z = 1'b1; wa_z = 3'd0; wd_z = 16'h0077; ra_z = 3'd0; rb_z = 3'd7;
    #1;
    checks++; if (s_ra_z !== 16'h0000) begin errors++; $display("FAIL z_r0_fwd got=%h exp=0000", s_ra_z); end
    cycle();
    checks++; if (s_ra_z !== 16'h0000) begin errors++; $display("FAIL z_r0_read got=%h exp=0000", s_ra_z); end
    wa_z = 3'd7; wd_z = 16'hBEEF;
    cycle();
    we_z = 1'b0;
    #1;
    checks++; if (s_rb_z !== 16'hBEEF) begin errors++; $display("FAIL z_r7 got=%h exp=beef", s_rb_z); end
    for (int n = 0; n < 80; n++) begin
      we_z = 1'($urandom_range(0, 1));
      wa_z = 3'($urandom); ra_z = 3'($urandom); rb_z = 3'($urandom);
      wd_z = 16'($urandom);
      #1;
      checks++; if (s_ra_z !== mz_read(ra_z)) begin errors++; $display("FAIL z_rand_s_ra n=%0d got=%h exp=%h", n, s_ra_z, mz_read(ra_z)); end
      checks++; if (s_rb_z !== mz_read(rb_z)) begin errors++; $display("FAIL z_rand_s_rb n=%0d got=%h exp=%h", n, s_rb_z, mz_read(rb_z)); end
      cycle();
    end
    we_z = 1'b0;
  endtask

  task automatic test_wide_sweep();
    int seen = 0;
    for (int i = 1; i < NRZ; i++) begin
      we_z = 1'b1; wa_z = 3'(i); wd_z = 16'(16'h1000 + i);
      cycle();
    end
    we_z = 1'b0; clr_z = 1'b1;
    cycle();
    clr_z = 1'b0;
    for (int k = 1; k <= 20 && seen == 0; k++) begin
      #1;
      if (clr_done_z === 1'b1) seen = k;
      else cycle();
    end
    checks++; if (seen != NRZ + 1) begin errors++; $display("FAIL z_sweep_latency got=%0d exp=%0d", seen, NRZ + 1); end
    cycle();
    checks++; if (busy_z !== 1'b0) begin errors++; $display("FAIL z_sweep_busy got=%b exp=0", busy_z); end
    for (int i = 0; i < NRZ; i++) memz[i] = 16'h0000;
    for (int p = 0; p < NRZ; p += 2) begin
      ra_z = 3'(p); rb_z = 3'(p + 1);
      #1;
      checks++; if (s_ra_z !== 16'h0000) begin errors++; $display("FAIL z_sweep r%0d got=%h exp=0000", p, s_ra_z); end
      checks++; if (s_rb_z !== 16'h0000) begin errors++; $display("FAIL z_sweep r%0d got=%h exp=0000", p + 1, s_rb_z); end
    end
  endtask

  initial begin
    we = 1'b0; clr = 1'b0; wa = '0; wd = '0; ra = '0; rb = '0;
    we_z = 1'b0; clr_z = 1'b0; wa_z = '0; wd_z = '0; ra_z = '0; rb_z = '0;
    m_reset();
    test_reset();
    test_write_read();
    test_clear_sweep();
    test_busy_block();
    test_priority_reset();
    test_bypass();
    test_random();
    test_zero_r0();
    test_wide_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_bank_param.md
Name: reg_bank_param

Overview:
- Parametrised successor to the processor's 4×8 register bank: N registers of DW bits, two combinational read ports, one independent write port.
- Write address is separate from the read addresses.
- Adds a multi-cycle sequenced clear command with busy/done handshake, an optional hardwired-zero R0, and optional write-to-read forwarding.
- Sits between the control unit (we/wa/clr) and the ALU operand path (s_ra/s_rb).

Parameters:
- DW, 8, data width in bits (≥1).
- NREGS, 4, number of registers (≥2, power of two).
- AW, $clog2(NREGS), address width; derived localparam, not overridable.
- ZERO_R0, 0, when 1 register 0 always reads 0 and ignores writes.

Ports:
- clk  in  1  clock, rising edge.
- r  in  1  asynchronous active-low reset.
- we  in  1  write enable.
- wa  in  AW  write address.
- wd  in  DW  write data.
- ra  in  AW  read address A.
- rb  in  AW  read address B.
- clr  in  1  clear request, sampled at posedge.
- s_ra  out  DW  register[ra], combinational.
- s_rb  out  DW  register[rb], combinational.
- busy  out  1  high while the clear sweep runs.
- clr_done  out  1  one-cycle pulse when the sweep completes.

Behaviour:
- Reset (r=0, asynchronous): all registers ← 0; FSM → IDLE; sweep index ← 0; busy=0; clr_done=0. Reads return 0 while reset is held.
- Reads are combinational from the register array; no read latency.
- Write: in IDLE with we=1, register[wa] ← wd at posedge; new value visible on reads from the next cycle.
- ZERO_R0=1: writes to address 0 are dropped; reads of address 0 return 0 unconditionally.
- FSM states:
  - IDLE: clr=1 at posedge → CLEAR with idx=0. clr has priority over we in the same cycle; that write is dropped.
  - CLEAR: each cycle register[idx] ← 0 and idx++. When idx=NREGS-1 is cleared → DONE.
  - DONE: clr_done=1 for exactly one cycle → IDLE.
- busy=1 in CLEAR and DONE; busy=0 in IDLE.
- Sweep latency: clr sampled at cycle t → busy rises at t+1, clr_done high at t+NREGS+1, busy low and writes accepted again at t+NREGS+2.
- During busy: we is ignored (no write, no error); clr re-requests are ignored; reads return current contents, partially cleared mid-sweep.
- Reset asserted mid-sweep: immediate zeroing, FSM → IDLE; no clr_done pulse.
- wa/ra/rb are fully decoded because NREGS is a power of two; no out-of-range case exists.

Optional Feature:
- Macro REG_BANK_BYPASS_EN.
- Defined: when an accepted write occurs (IDLE, we=1, not dropped by ZERO_R0) and ra==wa, s_ra returns wd in the same cycle; likewise for rb/s_rb.
- Not defined: reads return the stored (old) value until the next cycle.
- Forwarding never applies to dropped writes (busy, clr priority, or R0 with ZERO_R0=1).

Decomposition:
- Shared package reg_bank_pkg holds:
  - FSM state enum: IDLE, CLEAR, DONE.
  - Default DW/NREGS constants.
  - A function returning AW from NREGS.
- One sub-module, reg_bank_clr_seq, holds the FSM, sweep index, busy and clr_done, and outputs clear-enable and clear-index to the array.
- The array, write decode, ZERO_R0 and bypass muxes stay in reg_bank_param.

Test Plan:
- Reset/write/read: deassert r; write 8'hA5 to R2, 8'h3C to R3; ra=2, rb=3 → s_ra=A5, s_rb=3C next cycle; assert r asynchronously mid-cycle → both outputs 0 immediately.
- Clear sweep (NREGS=4): fill R0..R3 with 11,22,33,44; pulse clr at t → busy high at t+1..t+5, clr_done only at t+5, all reads 0 at t+6.
- Busy blocking: during the sweep drive we=1, wa=1, wd=FF and a second clr → R1 stays 0 after completion; exactly one clr_done pulse.
- Priority/reset mid-sweep: same-cycle clr=1, we=1 → write dropped; assert r two cycles into the sweep → busy=0, all registers 0, no clr_done.
- ZERO_R0=1: write 8'h77 to R0 → s_ra with ra=0 reads 00; DW=16, NREGS=8 write 16'hBEEF to R7 → reads BEEF.
- REG_BANK_BYPASS_EN: we=1, wa=ra=1, wd=5A with R1 holding 00 → s_ra=5A in the same cycle with the macro defined, 00 without it.
